// File: rtl/simd_add_pipe.sv
// simd_add_pipe: 2-stage packed-SIMD adder (8/16/32-bit lanes, 3-operand widening, 2*WIDTH add).
// Define SIMD_ADD_PIPE_SAT_EN to enable unsigned lane saturation in two-operand form.
module simd_add_pipe #(
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   form,
  input  logic [1:0]             precision,
  input  logic                   sub,
  input  logic                   sat,
  input  logic [WIDTH-1:0]       A,
  input  logic [WIDTH-1:0]       B,
  input  logic [WIDTH-1:0]       C,
  input  logic [WIDTH-1:0]       D,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       Y1,
  output logic [WIDTH-1:0]       Y2,
  output logic [WIDTH/8-1:0]     carry
);
  localparam int NBYTE = WIDTH / 8;
  logic [3:0][WIDTH-1:0] ya, yb;
  logic [3:0][NBYTE-1:0] ca;
  logic                  s1_valid, s1_p3, s1_cin;
  logic [WIDTH-1:0]      s1_y1, s1_y2, s1_hc;
  logic [NBYTE-1:0]      s1_carry;
  logic [WIDTH:0]        lo, hi;
  logic                  advance2, accept, sat_on;
`ifdef SIMD_ADD_PIPE_SAT_EN
  assign sat_on = sat & form;
`else
  logic unused_sat;
  assign unused_sat = sat;
  assign sat_on = 1'b0;
`endif
  // Every lane width is computed in parallel; the accept cycle picks one by precision.
  for (genvar p = 0; p < 3; p++) begin : g_prec
    localparam int L = 8 << p;
    for (genvar k = 0; k < WIDTH / L; k++) begin : g_lane
      logic [L:0]   s1, s2;
      logic [L+1:0] w;
      assign s1 = {1'b0, A[k*L +: L]} + {1'b0, sub ? ~C[k*L +: L] : C[k*L +: L]} + (L+1)'(sub);
      assign s2 = {1'b0, B[k*L +: L]} + {1'b0, sub ? ~D[k*L +: L] : D[k*L +: L]} + (L+1)'(sub);
      assign w  = (L+2)'(A[k*L +: L]) + (L+2)'(B[k*L +: L]) + (L+2)'(C[k*L +: L]);
      assign ya[p][k*L +: L] = !form ? w[L-1:0] :
                               (sat_on && (s1[L] ^ sub)) ? {L{~sub}} : s1[L-1:0];
      assign yb[p][k*L +: L] = !form ? {{(L-2){1'b0}}, w[L+1:L]} :
                               (sat_on && (s2[L] ^ sub)) ? {L{~sub}} : s2[L-1:0];
      assign ca[p][k*(L/8) +: L/8] = (L/8)'(form & s1[L]) << (L/8 - 1);
    end
  end
  assign ya[3] = '0;
  assign yb[3] = '0;
  assign ca[3] = '0;
  assign lo = {1'b0, B} + {1'b0, sub ? ~D : D} + (WIDTH+1)'(sub);
  assign hi = {1'b0, s1_y1} + {1'b0, s1_hc} + (WIDTH+1)'(s1_cin);
  assign advance2 = !out_valid || out_ready;
  assign in_ready = !s1_valid || advance2;
  assign accept   = in_valid && in_ready;
  // For the wide op, stage 1 keeps the raw high operands and the low-half carry.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_p3    <= 1'b0;
      s1_cin   <= 1'b0;
      s1_y1    <= '0;
      s1_y2    <= '0;
      s1_hc    <= '0;
      s1_carry <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (accept) begin
        s1_p3    <= &precision;
        s1_cin   <= lo[WIDTH];
        s1_y1    <= (&precision) ? A : ya[precision];
        s1_y2    <= (&precision) ? lo[WIDTH-1:0] : yb[precision];
        s1_hc    <= (sub && (&precision)) ? ~C : C;
        s1_carry <= ca[precision];
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      Y1        <= '0;
      Y2        <= '0;
      carry     <= '0;
    end else if (advance2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        Y1    <= s1_p3 ? hi[WIDTH-1:0] : s1_y1;
        Y2    <= s1_y2;
        carry <= s1_p3 ? {hi[WIDTH], {(NBYTE-1){1'b0}}} : s1_carry;
      end
    end
endmodule
